// File: rtl/div_job_sequencer_pkg.sv
// Shared definitions for the divider job sequencer: FSM encoding and select constants.
package div_job_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_A_ARM  = 3'd1,
    S_A_WAIT = 3'd2,
    S_GAP    = 3'd3,
    S_B_ARM  = 3'd4,
    S_B_WAIT = 3'd5,
    S_FIN    = 3'd6
  } state_t;

  localparam logic SEL_PAIR1 = 1'b1;
  localparam logic SEL_PAIR2 = 1'b0;

  localparam int unsigned DEFAULT_WIDTH = 12;

endpackage

// File: rtl/div_job_sequencer_watchdog.sv
// Per-job cycle watchdog: up-counter with synchronous clear, expires on the TIMEOUT-th counted cycle.
module div_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  // Count value equals cycles already spent in the job, so the expiring cycle is the TIMEOUT-th one.
  assign expired = (count_q == CW'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/div_job_sequencer.sv
// Runs job A (pair 1) then job B (pair 2) on the shared sequential divider and holds both quotients.
module div_job_sequencer
  import div_job_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned GAP     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             div_busy,
  input  logic             div_ready,
  input  logic [WIDTH-1:0] div_res,
  output logic             div_en,
  output logic             div_select,
  output logic [WIDTH-1:0] res_a,
  output logic [WIDTH-1:0] res_b,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  state_t             state_q, state_d;
  logic               div_en_q, div_en_d;
  logic               div_select_q, div_select_d;
  logic [WIDTH-1:0]   res_a_q, res_a_d;
  logic [WIDTH-1:0]   res_b_q, res_b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_err_q, timeout_err_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic               wd_clear, wd_enable, wd_expired;
  logic               job_a, in_wait, job_end;
  logic [WIDTH-1:0]   job_res;

  div_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    div_en_d      = div_en_q;
    div_select_d  = div_select_q;
    res_a_d       = res_a_q;
    res_b_d       = res_b_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    timeout_err_d = timeout_err_q;
    gap_cnt_d     = gap_cnt_q;
    wd_clear      = 1'b0;
    wd_enable     = 1'b0;
    job_a         = 1'b0;
    in_wait       = 1'b0;
    job_end       = 1'b0;
    job_res       = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_A_ARM;
          busy_d        = 1'b1;
          timeout_err_d = 1'b0;
          div_en_d      = 1'b1;
          div_select_d  = SEL_PAIR1;
          wd_clear      = 1'b1;
        end
      end

      S_A_ARM, S_A_WAIT, S_B_ARM, S_B_WAIT: begin
        wd_enable = 1'b1;
        job_a     = (state_q == S_A_ARM) || (state_q == S_A_WAIT);
        in_wait   = (state_q == S_A_WAIT) || (state_q == S_B_WAIT);
        // Ready is only trusted in WAIT; in ARM it may be left over from the previous job.
        if (in_wait && div_ready && !div_busy) begin
          job_end = 1'b1;
          job_res = div_res;
        end else if (wd_expired) begin
          job_end       = 1'b1;
          job_res       = '0;
          timeout_err_d = 1'b1;
        end else if (!in_wait && div_busy) begin
          state_d = job_a ? S_A_WAIT : S_B_WAIT;
        end

        if (job_end) begin
          div_en_d = 1'b0;
          if (job_a) begin
            res_a_d      = job_res;
            div_select_d = SEL_PAIR2;
            gap_cnt_d    = '0;
            state_d      = S_GAP;
          end else begin
            res_b_d = job_res;
            done_d  = 1'b1;
            state_d = S_FIN;
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP - 1)) begin
          state_d  = S_B_ARM;
          div_en_d = 1'b1;
          wd_clear = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      S_FIN: begin
        busy_d       = 1'b0;
        div_select_d = SEL_PAIR1;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      div_en_q      <= 1'b0;
      div_select_q  <= SEL_PAIR1;
      res_a_q       <= '0;
      res_b_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      div_en_q      <= div_en_d;
      div_select_q  <= div_select_d;
      res_a_q       <= res_a_d;
      res_b_q       <= res_b_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  assign div_en      = div_en_q;
  assign div_select  = div_select_q;
  assign res_a       = res_a_q;
  assign res_b       = res_b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

endmodule
